// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector MAC array.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // clog2 that never returns less than 1, so counters are always at least one bit wide
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator width: full-precision product plus growth for COLS additions
  function automatic int acc_width(input int width, input int cols);
    return 2 * width + clog2_min1(cols);
  endfunction

  // True when acc does not fit in a signed ow-bit value
  function automatic logic out_of_range(input logic signed [63:0] acc, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return (acc > hi) || (acc < lo);
  endfunction

  // Saturating conversion when sat=1; otherwise the value passes through and the
  // caller keeps only the low ow bits, which is plain two's-complement truncation
  function automatic logic signed [63:0] convert_out(input logic signed [63:0] acc,
                                                     input int ow, input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && (acc > hi)) return hi;
    if (sat && (acc < lo)) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One signed multiply-accumulate lane with zero-skip accumulation.
module mvm_mac_lane #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    first,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   base;

  assign prod = a * b;

  // Next accumulator value; a new row restarts from zero, zero operands leave it untouched
  always_comb begin
    base     = first ? '0 : acc;
    acc_next = base;
    if (en && (a != '0) && (b != '0)) acc_next = base + ACC_W'(prod);
  end

  // Accumulator register; masked (disabled) lanes hold their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc_next;
  end

endmodule

// File: rtl/matrix_vector_mac_array.sv
// Signed ROWS x COLS matrix times COLS vector, LANES rows computed per pass.
module matrix_vector_mac_array
  import mvm_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sat_mode,
  input  logic [ROWS*COLS*WIDTH-1:0]  matrix_a,
  input  logic [COLS*WIDTH-1:0]       vector_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROWS*OUT_WIDTH-1:0]   vector_c,
  output logic [ROWS-1:0]             ovf,
  output logic                        busy
);

  localparam int ACC_W = acc_width(WIDTH, COLS);
  localparam int RB_W  = clog2_min1(ROWS + LANES + 1);
  localparam int K_W   = clog2_min1(COLS);

  state_t                  state;
  logic [RB_W-1:0]         rb;
  logic [K_W-1:0]          k;
  logic signed [WIDTH-1:0] a_reg [ROWS][COLS];
  logic signed [WIDTH-1:0] b_reg [COLS];
  logic                    sat_reg;
  logic signed [ACC_W-1:0] row_acc [ROWS];
  logic signed [WIDTH-1:0] lane_a [LANES];
  logic signed [WIDTH-1:0] lane_b [LANES];
  logic                    lane_en [LANES];
  logic signed [ACC_W-1:0] lane_next [LANES];
  logic [ROWS*OUT_WIDTH-1:0] c_next;
  logic [ROWS-1:0]         ovf_next;
  logic                    accept;
  logic                    computing;
  logic                    last_col;
  logic                    first_col;

  assign accept    = in_valid && in_ready;
  assign computing = (state == COMPUTE);
  assign last_col  = (k == K_W'(COLS - 1));
  assign first_col = computing && (k == '0);

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rb        <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= COMPUTE;
            rb       <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            sat_reg  <= sat_mode;
          end
        end
        COMPUTE: begin
          if (last_col) begin
            k  <= '0;
            rb <= rb + RB_W'(LANES);
            if ((rb + RB_W'(LANES)) >= RB_W'(ROWS)) state <= DONE;
          end else begin
            k <= k + K_W'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) a_reg[r][c] <= '0;
      for (int c = 0; c < COLS; c++) b_reg[c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) a_reg[r][c] <= matrix_a[(r*COLS+c)*WIDTH +: WIDTH];
      for (int c = 0; c < COLS; c++) b_reg[c] <= vector_b[c*WIDTH +: WIDTH];
    end
  end

  // Lane row/column select; lanes past the last row and all lanes outside COMPUTE see zero operands
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l]  = '0;
      lane_b[l]  = '0;
      lane_en[l] = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (computing && ((rb + RB_W'(l)) == RB_W'(r))) begin
          lane_en[l] = 1'b1;
          for (int c = 0; c < COLS; c++) begin
            if (k == K_W'(c)) begin
              lane_a[l] = a_reg[r][c];
              lane_b[l] = b_reg[c];
            end
          end
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mvm_mac_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .first    (first_col),
      .en       (lane_en[l]),
      .a        (lane_a[l]),
      .b        (lane_b[l]),
      .acc_next (lane_next[l])
    );
  end

  // Row result store: each lane's final sum lands in its row at the end of a pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) row_acc[r] <= '0;
    end else if (accept) begin
      for (int r = 0; r < ROWS; r++) row_acc[r] <= '0;
    end else if (computing && last_col) begin
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < ROWS; r++)
          if (lane_en[l] && ((rb + RB_W'(l)) == RB_W'(r))) row_acc[r] <= lane_next[l];
    end
  end

  // Per-row conversion to the output width and overflow detection
  always_comb begin
    c_next   = '0;
    ovf_next = '0;
    for (int r = 0; r < ROWS; r++) begin
      c_next[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(convert_out(64'(row_acc[r]), OUT_WIDTH, sat_reg));
      ovf_next[r] = out_of_range(64'(row_acc[r]), OUT_WIDTH);
    end
  end

  // Result registers: loaded on the first DONE cycle, retained until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector_c <= '0;
      ovf      <= '0;
    end else if ((state == DONE) && !out_valid) begin
      vector_c <= c_next;
      ovf      <= ovf_next;
    end
  end

endmodule

// File: tb/tb_matrix_vector_mac_array.sv
// Directed bench for matrix_vector_mac_array: default 4x4x2 instance plus a 3x2 instance with a masked lane.
module tb_matrix_vector_mac_array;

  localparam int R = 4, C = 4, W = 8, L = 2, OW = 16;

  typedef struct packed {
    logic [R*OW-1:0] c;
    logic [R-1:0]    o;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, sat_mode;
  logic [R*C*W-1:0]  matrix_a;
  logic [C*W-1:0]    vector_b;
  logic              out_valid, out_ready, busy;
  logic [R*OW-1:0]   vector_c;
  logic [R-1:0]      ovf;

  logic              in_valid3, in_ready3, sat_mode3;
  logic [3*2*W-1:0]  matrix_a3;
  logic [2*W-1:0]    vector_b3;
  logic              out_valid3, out_ready3, busy3;
  logic [3*OW-1:0]   vector_c3;
  logic [2:0]        ovf3;

  int   checks = 0;
  int   errors = 0;
  int   am [R][C];
  int   bv [C];
  exp_t sbq [$];

  always #5 clk = ~clk;

  matrix_vector_mac_array #(.ROWS(R), .COLS(C), .WIDTH(W), .LANES(L), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sat_mode(sat_mode),
    .matrix_a(matrix_a), .vector_b(vector_b), .out_valid(out_valid), .out_ready(out_ready),
    .vector_c(vector_c), .ovf(ovf), .busy(busy));

  matrix_vector_mac_array #(.ROWS(3), .COLS(2), .WIDTH(W), .LANES(2), .OUT_WIDTH(OW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .sat_mode(sat_mode3),
    .matrix_a(matrix_a3), .vector_b(vector_b3), .out_valid(out_valid3), .out_ready(out_ready3),
    .vector_c(vector_c3), .ovf(ovf3), .busy(busy3));

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot products, then clamp or wrap to OW bits
  function automatic exp_t model(input logic sat);
    exp_t   e;
    longint acc, v;
    e = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++) acc += longint'(am[r][c]) * longint'(bv[c]);
      e.o[r] = (acc > 32767) || (acc < -32768);
      v = acc;
      if (sat && acc > 32767)  v = 32767;
      if (sat && acc < -32768) v = -32768;
      e.c[r*OW +: OW] = 16'(v);
    end
    return e;
  endfunction

  task automatic pack();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) matrix_a[(r*C+c)*W +: W] = am[r][c][7:0];
    for (int c = 0; c < C; c++) vector_b[c*W +: W] = bv[c][7:0];
  endtask

  task automatic fill(input int av, input int bval);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) am[r][c] = av;
    for (int c = 0; c < C; c++) bv[c] = bval;
  endtask

  // One full transaction on the default instance, with optional back-pressure in DONE
  task automatic run_op(input logic sat, input int hold);
    exp_t e;
    int   n;
    sbq.push_back(model(sat));
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(negedge clk);
    pack();
    sat_mode = sat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    matrix_a = ~matrix_a;
    vector_b = ~vector_b;
    sat_mode = ~sat;
    check("busy_compute", 64'({busy, in_ready}), 64'b10);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 60);
    check("latency", 64'(n), 64'd9);
    e = sbq.pop_front();
    check("vector_c", vector_c, e.c);
    check("ovf", 64'(ovf), 64'(e.o));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid_ready", 64'({out_valid, in_ready, busy}), 64'b101);
      check("hold_vector_c", vector_c, e.c);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_flags", 64'({out_valid, in_ready, busy}), 64'b010);
    check("post_hs_retain", vector_c, e.c);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_mode = 1'b0;
    matrix_a = '0; vector_b = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; sat_mode3 = 1'b0; matrix_a3 = '0; vector_b3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, busy, ovf}), 64'd0);
    check("reset_vector_c", vector_c, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Identity matrix, B = [1,-2,3,-4]
    fill(0, 0);
    for (int i = 0; i < R; i++) am[i][i] = 1;
    bv[0] = 1; bv[1] = -2; bv[2] = 3; bv[3] = -4;
    run_op(1'b1, 0);

    // Positive overflow: saturate, then truncate
    fill(127, 127);
    run_op(1'b1, 0);
    run_op(1'b0, 0);

    // Most negative operands, saturate
    fill(-128, -128);
    run_op(1'b1, 0);

    // Row 0 = [-1,0,0,0] against B = -128 (128 fits), other rows random
    for (int r = 1; r < R; r++)
      for (int c = 0; c < C; c++) am[r][c] = int'($urandom_range(255)) - 128;
    for (int c = 0; c < C; c++) begin am[0][c] = 0; bv[c] = -128; end
    am[0][0] = -1;
    run_op(1'b1, 0);

    // Random operand sets, alternating mode
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) am[r][c] = int'($urandom_range(255)) - 128;
      for (int c = 0; c < C; c++) bv[c] = int'($urandom_range(255)) - 128;
      run_op(t[0], 0);
    end

    // Back-pressure: result held five cycles while in_valid pulses are ignored
    fill(3, -5);
    am[2][1] = 100;
    run_op(1'b1, 5);

    // Reset in the middle of COMPUTE aborts without residue
    fill(50, 60);
    @(negedge clk);
    pack(); sat_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({out_valid, busy, ovf}), 64'd0);
    check("abort_vector_c", vector_c, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    fill(0, 0);
    for (int i = 0; i < R; i++) am[i][R-1-i] = 2;
    bv[0] = 7; bv[1] = -9; bv[2] = 11; bv[3] = -13;
    run_op(1'b1, 0);

    // 3x2 instance: rows 0,1 in pass 0, row 2 alone in pass 1 with lane 1 masked
    @(negedge clk);
    matrix_a3 = {8'sd6, 8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1};
    vector_b3 = {8'sd1, 8'sd1};
    sat_mode3 = 1'b1;
    in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid3 && n < 60);
    check("latency3", 64'(n), 64'd5);
    check("vector_c3", 64'(vector_c3), 64'({16'd11, 16'd7, 16'd3}));
    check("ovf3", 64'(ovf3), 64'd0);
    @(negedge clk) out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    check("post_hs3", 64'({out_valid3, in_ready3}), 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
